programmable_frequency_divider: RTL and testbench

Runtime-programmable successor to the fixed 100 MHz to 1 MHz divider. It derives a single-cycle clock-enable tick and a registered, near-50%-duty square output from clk_100MHz, with a divide ratio that can be changed on the fly. New ratios are staged through a shadow register and applied only at a period boundary, so no output glitches. It feeds the DDS sample-rate and phase-accumulator enable logic.

---
 rtl/fdiv_pkg.sv | 18 +
 rtl/programmable_frequency_divider.sv | 94 +++++++++
 tb/tb_programmable_frequency_divider.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fdiv_pkg.sv
// Shared constants and the ratio clamp for the programmable frequency divider.
package fdiv_pkg;

  // Default width of the divide ratio and the period counter
  localparam int FDIV_CNT_WIDTH = 16;

  // Ratio loaded at reset: 100 MHz in, 1 MHz out
  localparam int FDIV_DIV_DEFAULT = 100;

  // Smallest usable ratio; one low cycle and one high cycle per period
  localparam int FDIV_DIV_MIN = 2;

  // Raise any ratio below the minimum to the minimum; there is no error flag
  function automatic int clamp_div(input int v);
    return (v < FDIV_DIV_MIN) ? FDIV_DIV_MIN : v;
  endfunction

endpackage

// File: rtl/programmable_frequency_divider.sv
// Runtime-programmable clock divider: a one-cycle tick and a near-50% square
// output, both with period N. A new N is staged in a shadow register and only
// takes effect at a period boundary, so the outputs never glitch.
module programmable_frequency_divider
  import fdiv_pkg::*;
#(
  parameter int CNT_WIDTH   = FDIV_CNT_WIDTH,
  parameter int DIV_DEFAULT = FDIV_DIV_DEFAULT
) (
  input  logic                 clk_100MHz,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sync,
  input  logic [CNT_WIDTH-1:0] div_value,
  input  logic                 div_load,
  output logic                 tick,
  output logic                 clk_out,
  output logic                 div_ack,
  output logic [CNT_WIDTH-1:0] div_active
);

  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] N_RESET = CNT_WIDTH'(clamp_div(DIV_DEFAULT));

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] n_act;
  logic [CNT_WIDTH-1:0] n_pend;
  logic                 pend_valid;

  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] n_act_next;
  logic [CNT_WIDTH-1:0] n_pend_next;
  logic                 pend_valid_next;
  logic                 tick_next;
  logic                 clk_out_next;
  logic                 div_ack_next;
  logic                 wrap;
  logic                 restart;
  logic                 apply;

  // Next-state decode: period counter, shadow-register apply, output decode
  always_comb begin
    wrap    = (cnt == n_act - ONE);
    // Disable, sync and wrap all bring the counter back to the start of a
    // period, and each of them is a safe point to swap in a staged ratio.
    restart = !en || sync || wrap;
    // Only a value staged in an earlier cycle is applied, so a load landing
    // on a boundary waits for the next one.
    apply   = restart && pend_valid;

    cnt_next   = restart ? '0 : cnt + ONE;
    n_act_next = apply ? n_pend : n_act;

    n_pend_next     = n_pend;
    pend_valid_next = pend_valid;
    if (apply) begin
      pend_valid_next = 1'b0;
    end
    // A load in the apply cycle re-stages; the old staged value still applies now
    if (div_load) begin
      n_pend_next     = CNT_WIDTH'(clamp_div(32'(div_value)));
      pend_valid_next = 1'b1;
    end

    // Outputs are decoded from the next state so they line up with cnt
    tick_next    = en && (cnt_next == n_act_next - ONE);
    clk_out_next = en && (cnt_next >= (n_act_next >> 1));
    div_ack_next = apply;
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      n_act      <= N_RESET;
      n_pend     <= '0;
      pend_valid <= 1'b0;
      tick       <= 1'b0;
      clk_out    <= 1'b0;
      div_ack    <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      n_act      <= n_act_next;
      n_pend     <= n_pend_next;
      pend_valid <= pend_valid_next;
      tick       <= tick_next;
      clk_out    <= clk_out_next;
      div_ack    <= div_ack_next;
    end
  end

  assign div_active = n_act;

endmodule

// File: tb/tb_programmable_frequency_divider.sv
// Scoreboard bench for programmable_frequency_divider: the stimulus side runs a
// period-position reference model and queues the expected outputs of every
// cycle; a monitor on the falling edge pops and compares them.
module tb_programmable_frequency_divider;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sync;
  logic [15:0] div_value;
  logic        div_load;
  logic        tick;
  logic        clk_out;
  logic        div_ack;
  logic [15:0] div_active;

  programmable_frequency_divider dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .en         (en),
    .sync       (sync),
    .div_value  (div_value),
    .div_load   (div_load),
    .tick       (tick),
    .clk_out    (clk_out),
    .div_ack    (div_ack),
    .div_active (div_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit tick;
    bit clk;
    bit ack;
    int act;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: position within the current period, active ratio,
  // staged ratio (-1 when nothing is staged)
  int m_pos  = 0;
  int m_n    = 100;
  int m_pend = -1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_n    = 100;
    m_pend = -1;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit   restart;
    exp_t e;
    restart = !en || sync || (m_pos == m_n - 1);
    e.ack = 1'b0;
    if (restart && m_pend >= 0) begin
      m_n    = m_pend;
      m_pend = -1;
      e.ack  = 1'b1;
    end
    m_pos = restart ? 0 : m_pos + 1;
    if (div_load) m_pend = (int'(div_value) < 2) ? 2 : int'(div_value);
    e.tick = en && (m_pos == m_n - 1);
    e.clk  = en && (m_pos >= m_n / 2);
    e.act  = m_n;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, let the edge happen, queue the expectation
  task automatic step(input bit e, input bit s, input bit ld, input logic [15:0] v);
    en        = e;
    sync      = s;
    div_load  = ld;
    div_value = v;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic run_until_pos(input int p);
    for (int k = 0; k < 70000 && m_pos != p; k++) step(1'b1, 1'b0, 1'b0, 16'd0);
    if (m_pos != p) begin
      errors++;
      $display("FAIL reach_pos: position %0d never reached (at %0d)", p, m_pos);
    end
  endtask

  // Monitor: compare every registered output once per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst && sb.size() > 0) begin
        e = sb.pop_front();
        chk("tick", int'(tick), int'(e.tick));
        chk("clk_out", int'(clk_out), int'(e.clk));
        chk("div_ack", int'(div_ack), int'(e.ack));
        chk("div_active", int'(div_active), e.act);
        if (e.ack) $display("ack at cycle %0d: ratio now %0d", cyc, e.act);
      end
    end
  end

  // Stimulus
  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    sync      = 1'b0;
    div_load  = 1'b0;
    div_value = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tick", int'(tick), 0);
    chk("reset_clk_out", int'(clk_out), 0);
    chk("reset_div_ack", int'(div_ack), 0);
    chk("reset_div_active", int'(div_active), 100);
    #1;
    rst = 1'b1;
    model_reset();
    $display("phase: default ratio 100");
    repeat (250) step(1'b1, 1'b0, 1'b0, 16'd0);

    $display("phase: disable at position 40 for 5 cycles");
    run_until_pos(40);
    repeat (5) step(1'b0, 1'b0, 1'b0, 16'd0);
    repeat (120) step(1'b1, 1'b0, 1'b0, 16'd0);

    $display("phase: sync at position 60");
    run_until_pos(60);
    step(1'b1, 1'b1, 1'b0, 16'd0);
    repeat (110) step(1'b1, 1'b0, 1'b0, 16'd0);

    $display("phase: async reset at position 73 with a ratio staged");
    run_until_pos(71);
    step(1'b1, 1'b0, 1'b1, 16'd9);
    step(1'b1, 1'b0, 1'b0, 16'd0);
    chk("pre_reset_clk_out", int'(clk_out), 1);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("async_tick", int'(tick), 0);
    chk("async_clk_out", int'(clk_out), 0);
    chk("async_div_ack", int'(div_ack), 0);
    chk("async_div_active", int'(div_active), 100);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    repeat (110) step(1'b1, 1'b0, 1'b0, 16'd0);

    $display("phase: load 7 at position 20");
    run_until_pos(20);
    step(1'b1, 1'b0, 1'b1, 16'd7);
    repeat (120) step(1'b1, 1'b0, 1'b0, 16'd0);

    $display("phase: load 10 then 12 before a wrap");
    run_until_pos(1);
    step(1'b1, 1'b0, 1'b1, 16'd10);
    step(1'b1, 1'b0, 1'b1, 16'd12);
    repeat (40) step(1'b1, 1'b0, 1'b0, 16'd0);

    $display("phase: load 0, then load 1 (both clamp to 2)");
    step(1'b1, 1'b0, 1'b1, 16'd0);
    repeat (30) step(1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b1, 1'b0, 1'b1, 16'd5);
    repeat (10) step(1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b1, 1'b0, 1'b1, 16'd1);
    repeat (20) step(1'b1, 1'b0, 1'b0, 16'd0);

    $display("phase: randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) != 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 24) == 0,
           16'($urandom_range(0, 24)));
    end
    step(1'b1, 1'b0, 1'b0, 16'd0);

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
